exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Exception/interrupt sequencer for the CPU and its CP0 register block; sits at the MEM commit point of the pipeline.
- Collects per-instruction exception flags, synchronises hardware interrupts, and picks the highest-priority event.
- Drives the CP0 exception-entry and ERET strobes, then flushes the pipeline and redirects fetch to the handler address or to EPC.

Parameters:
- HANDLER_ADDR, 32'hBFC00380, exception vector (Bev=1 fixed).
- FLUSH_CYCLES, 2, extra cycles flush_o stays high after the trap/eret cycle (1..7).
- SYNC_STAGES, 2, flop depth of the hw_int synchroniser (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- commit_valid_i  in  1  valid instruction in MEM this cycle.
- stall_i  in  1  pipeline stalled; no commit and no event accepted.
- pc_i  in  32  PC of the committing instruction.
- in_delay_slot_i  in  1  committing instruction is in a delay slot.
- if_adel_i  in  1  fetch address error carried with the instruction.
- id_ri_i  in  1  reserved-instruction flag.
- id_sys_i  in  1  SYSCALL flag.
- id_bp_i  in  1  BREAK flag.
- ex_ov_i  in  1  overflow flag.
- mem_adel_i  in  1  load address error flag.
- mem_ades_i  in  1  store address error flag.
- mem_addr_i  in  32  data virtual address.
- eret_i  in  1  committing instruction is ERET.
- hw_int_async_i  in  6  raw external interrupts.
- status_i  in  32  CP0 Status (IM[15:8], EXL[1], IE[0]).
- cause_i  in  32  CP0 Cause (IP[15:8]).
- epc_i  in  32  CP0 EPC.
- hw_int_o  out  6  synchronised interrupts to CP0.
- exc_valid_o  out  1  one-cycle exception-entry strobe to CP0.
- exc_code_o  out  5  ExcCode.
- exc_pc_o  out  32  equals pc_i at trap.
- exc_bd_o  out  1  delay-slot flag.
- badvaddr_o  out  32  faulting address.
- eret_o  out  1  one-cycle ERET strobe to CP0.
- cancel_o  out  1  suppress the committing instruction's writeback/store.
- flush_o  out  1  flush all pipeline stages.
- redirect_valid_o  out  1  one-cycle fetch redirect.
- redirect_pc_o  out  32  redirect target.

Behaviour:
- Reset: all outputs 0, FSM IDLE, synchroniser flops 0.
- int_pending = status_i[0] & ~status_i[1] & |(status_i[15:8] & cause_i[15:8]).
- accept = commit_valid_i & ~stall_i & (state == IDLE).
- Priority, high to low:
  - INT(0x00)
  - if_adel(0x04, badvaddr = pc_i)
  - RI(0x0a)
  - SYS(0x08)
  - BP(0x09)
  - OV(0x0c)
  - mem_adel(0x04, badvaddr = mem_addr_i)
  - mem_ades(0x05, badvaddr = mem_addr_i)
- badvaddr_o = 0 for non-address exceptions.
- FSM states: IDLE, DRAIN.
- IDLE, accept with any exception/int:
  - Same cycle (combinational, zero latency): exc_valid_o, cancel_o, flush_o and redirect_valid_o = 1; redirect_pc_o = HANDLER_ADDR; exc_* fields valid.
  - Next state DRAIN, counter loaded with FLUSH_CYCLES.
- IDLE, accept with eret_i and no exception:
  - Same cycle: eret_o, flush_o and redirect_valid_o = 1; redirect_pc_o = epc_i.
  - Next state DRAIN.
- Exception and eret_i on the same instruction: the exception wins and eret_o stays 0.
- DRAIN: flush_o = 1; counter decrements each cycle; when it reaches 1, next state is IDLE. New events are ignored and not latched; they re-present on a later commit.
- stall_i high in IDLE: no strobes. Events are taken on the first unstalled commit cycle.
- Reset asserted mid-DRAIN: immediate return to IDLE with all outputs 0.

Decomposition:
- Shared package holds: ExcCode constants (INT, ADEL, ADES, SYS, BP, RI, OV), HANDLER_ADDR, and CP0 Status/Cause bit-position constants.
- Sub-module int_sync: SYNC_STAGES-deep 6-bit synchroniser with async active-low reset, producing hw_int_o.

Test Plan:
- Commit with ex_ov_i=1 and pc_i=0x1000 -> same cycle: exc_valid_o=1, exc_code_o=0x0c, redirect_pc_o=0xBFC00380; flush_o high 3 cycles total; then IDLE.
- if_adel_i and mem_ades_i together, pc_i=0x1002 -> exc_code_o=0x04, badvaddr_o=0x1002.
- Status=0x0000_0401, hw_int_async_i[0]=1 -> after 2 clk, hw_int_o[0]=1. With cause_i IP2 set, the next commit traps with code 0x00 and cancel_o=1. The same stimulus with EXL=1 produces no trap.
- eret_i with epc_i=0x2000 -> eret_o=1, redirect_pc_o=0x2000. Then id_sys_i during DRAIN -> ignored.
- stall_i=1 with id_bp_i=1 held 3 cycles -> no strobe; the first unstalled cycle gives code 0x09 exactly once.
- rst_n low during DRAIN -> flush_o=0 immediately. After release, a commit traps normally.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl shared definitions: ExcCodes, vector, CP0 bit positions,
// FSM state type and the exception priority picker.
package exc_ctrl_pkg;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0a;
   localparam logic [4:0] EXC_OV   = 5'h0c;

   localparam logic [31:0] EXC_HANDLER_ADDR = 32'hBFC00380;

   localparam int ST_IE    = 0;
   localparam int ST_EXL   = 1;
   localparam int ST_IM_LO = 8;
   localparam int ST_IM_HI = 15;
   localparam int CA_IP_LO = 8;
   localparam int CA_IP_HI = 15;

   localparam int NUM_HW_INT = 6;

   typedef enum logic {
      S_IDLE,
      S_DRAIN
   } state_e;

   typedef enum logic [1:0] {
      BV_NONE,
      BV_PC,
      BV_MEM
   } bv_sel_e;

   typedef struct packed {
      logic if_adel;
      logic ri;
      logic sys;
      logic bp;
      logic ov;
      logic mem_adel;
      logic mem_ades;
   } exc_flags_t;

   typedef struct packed {
      logic       hit;
      logic [4:0] code;
      bv_sel_e    bv_sel;
   } exc_sel_t;

   // Several flags may be set at once, so this is a strict priority chain.
   function automatic exc_sel_t exc_pick(input logic int_p,
                                         input exc_flags_t f);
      exc_sel_t s;
      s = '{hit: 1'b1, code: EXC_INT, bv_sel: BV_NONE};
      if (int_p)           s.code = EXC_INT;
      else if (f.if_adel)  begin
         s.code   = EXC_ADEL;
         s.bv_sel = BV_PC;
      end
      else if (f.ri)       s.code = EXC_RI;
      else if (f.sys)      s.code = EXC_SYS;
      else if (f.bp)       s.code = EXC_BP;
      else if (f.ov)       s.code = EXC_OV;
      else if (f.mem_adel) begin
         s.code   = EXC_ADEL;
         s.bv_sel = BV_MEM;
      end
      else if (f.mem_ades) begin
         s.code   = EXC_ADES;
         s.bv_sel = BV_MEM;
      end
      else                 s.hit = 1'b0;
      return s;
   endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// exc_ctrl_int_sync: multi-flop synchroniser for the raw
// external interrupt lines.
module exc_ctrl_int_sync
   import exc_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int W           = NUM_HW_INT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] async_i,
   output logic [W-1:0] sync_o
);

   logic [SYNC_STAGES-1:0][W-1:0] sync_d;
   logic [SYNC_STAGES-1:0][W-1:0] sync_q;

   // Shift the raw lines one stage deeper each cycle.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
   end

   // Synchroniser flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
   end

   assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: commit-point exception/interrupt sequencer; raises CP0
// strobes, flushes the pipe and redirects fetch to handler or EPC.
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter logic [31:0] HANDLER_ADDR = EXC_HANDLER_ADDR,
   parameter int          FLUSH_CYCLES = 2,
   parameter int          SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        commit_valid_i,
   input  logic        stall_i,
   input  logic [31:0] pc_i,
   input  logic        in_delay_slot_i,
   input  logic        if_adel_i,
   input  logic        id_ri_i,
   input  logic        id_sys_i,
   input  logic        id_bp_i,
   input  logic        ex_ov_i,
   input  logic        mem_adel_i,
   input  logic        mem_ades_i,
   input  logic [31:0] mem_addr_i,
   input  logic        eret_i,
   input  logic [5:0]  hw_int_async_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   output logic [5:0]  hw_int_o,
   output logic        exc_valid_o,
   output logic [4:0]  exc_code_o,
   output logic [31:0] exc_pc_o,
   output logic        exc_bd_o,
   output logic [31:0] badvaddr_o,
   output logic        eret_o,
   output logic        cancel_o,
   output logic        flush_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o
);

   localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

   state_e     state_d, state_q;
   logic [2:0] cnt_d, cnt_q;

   exc_flags_t flags;
   exc_sel_t   sel;
   logic       int_pending;
   logic       accept;
   logic       take_exc;
   logic       take_eret;
   logic [31:0] bv;

   logic unused_bits;
   assign unused_bits = ^{status_i[31:16], status_i[7:2],
                          cause_i[31:16], cause_i[7:0]};

   exc_ctrl_int_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .W           (NUM_HW_INT)
   ) u_int_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (hw_int_async_i),
      .sync_o  (hw_int_o)
   );

   assign flags = '{if_adel:  if_adel_i,
                    ri:       id_ri_i,
                    sys:      id_sys_i,
                    bp:       id_bp_i,
                    ov:       ex_ov_i,
                    mem_adel: mem_adel_i,
                    mem_ades: mem_ades_i};

   // Event qualification and priority selection.
   always_comb begin
      int_pending = status_i[ST_IE] & ~status_i[ST_EXL] &
                    |(status_i[ST_IM_HI:ST_IM_LO] &
                      cause_i[CA_IP_HI:CA_IP_LO]);
      accept      = commit_valid_i & ~stall_i & (state_q == S_IDLE);
      sel         = exc_pick(int_pending, flags);
      take_exc    = accept & sel.hit;
      take_eret   = accept & eret_i & ~sel.hit;
   end

   // Faulting address for the selected exception.
   always_comb begin
      bv = '0;
      unique case (sel.bv_sel)
         BV_PC:   bv = pc_i;
         BV_MEM:  bv = mem_addr_i;
         BV_NONE: bv = '0;
         default: bv = '0;
      endcase
   end

   // Next state, drain counter and zero-latency strobes.
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      exc_valid_o      = 1'b0;
      exc_code_o       = '0;
      exc_pc_o         = '0;
      exc_bd_o         = 1'b0;
      badvaddr_o       = '0;
      eret_o           = 1'b0;
      cancel_o         = 1'b0;
      flush_o          = 1'b0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      case (state_q)
         S_IDLE: begin
            if (take_exc) begin
               exc_valid_o      = 1'b1;
               exc_code_o       = sel.code;
               exc_pc_o         = pc_i;
               exc_bd_o         = in_delay_slot_i;
               badvaddr_o       = bv;
               cancel_o         = 1'b1;
               flush_o          = 1'b1;
               redirect_valid_o = 1'b1;
               redirect_pc_o    = HANDLER_ADDR;
               state_d          = S_DRAIN;
               cnt_d            = FLUSH_LD;
            end else if (take_eret) begin
               eret_o           = 1'b1;
               flush_o          = 1'b1;
               redirect_valid_o = 1'b1;
               redirect_pc_o    = epc_i;
               state_d          = S_DRAIN;
               cnt_d            = FLUSH_LD;
            end
         end
         S_DRAIN: begin
            flush_o = 1'b1;
            if (cnt_q <= 3'd1) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and drain counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed vectors with a scoreboard queue; a monitor
// pops and checks every strobe the DUT presents.
module tb_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        commit_valid_i, stall_i, in_delay_slot_i;
   logic        if_adel_i, id_ri_i, id_sys_i, id_bp_i, ex_ov_i;
   logic        mem_adel_i, mem_ades_i, eret_i;
   logic [31:0] pc_i, mem_addr_i, status_i, cause_i, epc_i;
   logic [5:0]  hw_int_async_i;
   logic [5:0]  hw_int_o;
   logic        exc_valid_o, exc_bd_o, eret_o, cancel_o;
   logic        flush_o, redirect_valid_o;
   logic [4:0]  exc_code_o;
   logic [31:0] exc_pc_o, badvaddr_o, redirect_pc_o;

   localparam logic [31:0] HV = 32'hBFC00380;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        exc;
      logic        eret;
      logic [4:0]  code;
      logic [31:0] pc;
      logic        bd;
      logic [31:0] badv;
      logic [31:0] rpc;
      logic        cancel;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      logic [6:0]  f;
      logic        er;
      logic [31:0] pc;
      logic [31:0] ma;
      logic [4:0]  code;
      logic [31:0] bv;
   } vec_t;

   vec_t tv[$];

   exc_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .commit_valid_i   (commit_valid_i),
      .stall_i          (stall_i),
      .pc_i             (pc_i),
      .in_delay_slot_i  (in_delay_slot_i),
      .if_adel_i        (if_adel_i),
      .id_ri_i          (id_ri_i),
      .id_sys_i         (id_sys_i),
      .id_bp_i          (id_bp_i),
      .ex_ov_i          (ex_ov_i),
      .mem_adel_i       (mem_adel_i),
      .mem_ades_i       (mem_ades_i),
      .mem_addr_i       (mem_addr_i),
      .eret_i           (eret_i),
      .hw_int_async_i   (hw_int_async_i),
      .status_i         (status_i),
      .cause_i          (cause_i),
      .epc_i            (epc_i),
      .hw_int_o         (hw_int_o),
      .exc_valid_o      (exc_valid_o),
      .exc_code_o       (exc_code_o),
      .exc_pc_o         (exc_pc_o),
      .exc_bd_o         (exc_bd_o),
      .badvaddr_o       (badvaddr_o),
      .eret_o           (eret_o),
      .cancel_o         (cancel_o),
      .flush_o          (flush_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name,
                               input logic [31:0] act,
                               input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void push_exc(input logic [4:0] code,
                                    input logic [31:0] pc,
                                    input logic bd,
                                    input logic [31:0] badv);
      exp_t e;
      e = '{exc: 1'b1, eret: 1'b0, code: code, pc: pc, bd: bd,
            badv: badv, rpc: HV, cancel: 1'b1};
      sb.push_back(e);
   endfunction

   function automatic void push_eret(input logic [31:0] rpc);
      exp_t e;
      e = '{exc: 1'b0, eret: 1'b1, code: 5'h0, pc: 32'h0, bd: 1'b0,
            badv: 32'h0, rpc: rpc, cancel: 1'b0};
      sb.push_back(e);
   endfunction

   // Monitor: every strobe must match the oldest expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (exc_valid_o || eret_o || redirect_valid_o) begin
         if (sb.size() == 0) begin
            chk("unexpected_strobe",
                {29'd0, exc_valid_o, eret_o, redirect_valid_o}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("exc_valid", {31'd0, exc_valid_o}, {31'd0, e.exc});
            chk("eret",      {31'd0, eret_o},      {31'd0, e.eret});
            chk("exc_code",  {27'd0, exc_code_o},  {27'd0, e.code});
            chk("exc_pc",    exc_pc_o,             e.pc);
            chk("exc_bd",    {31'd0, exc_bd_o},    {31'd0, e.bd});
            chk("badvaddr",  badvaddr_o,           e.badv);
            chk("redir_pc",  redirect_pc_o,        e.rpc);
            chk("cancel",    {31'd0, cancel_o},    {31'd0, e.cancel});
            chk("flush_on",  {31'd0, flush_o},     32'd1);
         end
      end
   end

   task automatic clear_inputs();
      commit_valid_i  = 0;
      stall_i         = 0;
      in_delay_slot_i = 0;
      if_adel_i       = 0;
      id_ri_i         = 0;
      id_sys_i        = 0;
      id_bp_i         = 0;
      ex_ov_i         = 0;
      mem_adel_i      = 0;
      mem_ades_i      = 0;
      eret_i          = 0;
      pc_i            = 0;
      mem_addr_i      = 0;
   endtask

   task automatic drive_commit(input logic [31:0] pc,
                               input logic [6:0] f,
                               input logic er,
                               input logic bd,
                               input logic [31:0] ma);
      commit_valid_i  = 1;
      pc_i            = pc;
      if_adel_i       = f[0];
      id_ri_i         = f[1];
      id_sys_i        = f[2];
      id_bp_i         = f[3];
      ex_ov_i         = f[4];
      mem_adel_i      = f[5];
      mem_ades_i      = f[6];
      eret_i          = er;
      in_delay_slot_i = bd;
      mem_addr_i      = ma;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (flush_o && n < 16) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle", {31'd0, flush_o}, 32'd0);
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n          = 0;
      clear_inputs();
      hw_int_async_i = 0;
      status_i       = 0;
      cause_i        = 0;
      epc_i          = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_flush",  {31'd0, flush_o},          32'd0);
      chk("rst_exc",    {31'd0, exc_valid_o},      32'd0);
      chk("rst_redir",  {31'd0, redirect_valid_o}, 32'd0);
      chk("rst_hwint",  {26'd0, hw_int_o},         32'd0);
      next_cycle();
      rst_n = 1;
      next_cycle();

      // Overflow trap and flush duration.
      push_exc(5'h0c, 32'h1000, 1'b0, 32'h0);
      drive_commit(32'h1000, 7'h10, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("ov_flush0", {31'd0, flush_o}, 32'd1);
      next_cycle();
      clear_inputs();
      @(negedge clk);
      chk("ov_flush1", {31'd0, flush_o}, 32'd1);
      @(negedge clk);
      chk("ov_flush2", {31'd0, flush_o}, 32'd1);
      @(negedge clk);
      chk("ov_flush3", {31'd0, flush_o}, 32'd0);
      next_cycle();

      // Priority table.
      tv.push_back('{7'h41, 1'b0, 32'h1002, 32'h3000, 5'h04, 32'h1002});
      tv.push_back('{7'h0e, 1'b0, 32'h1010, 32'h0,    5'h0a, 32'h0});
      tv.push_back('{7'h1c, 1'b0, 32'h1014, 32'h0,    5'h08, 32'h0});
      tv.push_back('{7'h38, 1'b0, 32'h1018, 32'h3008, 5'h09, 32'h0});
      tv.push_back('{7'h30, 1'b0, 32'h101c, 32'h300c, 5'h0c, 32'h0});
      tv.push_back('{7'h60, 1'b0, 32'h1020, 32'h3004, 5'h04, 32'h3004});
      tv.push_back('{7'h40, 1'b0, 32'h1024, 32'h3007, 5'h05, 32'h3007});
      tv.push_back('{7'h02, 1'b1, 32'h1028, 32'h0,    5'h0a, 32'h0});
      foreach (tv[i]) begin
         epc_i = 32'h5550;
         push_exc(tv[i].code, tv[i].pc, 1'b0, tv[i].bv);
         drive_commit(tv[i].pc, tv[i].f, tv[i].er, 1'b0, tv[i].ma);
         next_cycle();
         clear_inputs();
         wait_idle();
      end

      // Interrupt synchronisation and trap.
      status_i       = 32'h0000_0401;
      hw_int_async_i = 6'h01;
      @(negedge clk);
      chk("sync_0clk", {26'd0, hw_int_o}, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("sync_1clk", {26'd0, hw_int_o}, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("sync_2clk", {26'd0, hw_int_o}, 32'h1);
      next_cycle();
      cause_i = 32'h0000_0400;
      push_exc(5'h00, 32'h1100, 1'b1, 32'h0);
      drive_commit(32'h1100, 7'h00, 1'b0, 1'b1, 32'h0);
      next_cycle();
      clear_inputs();
      wait_idle();
      status_i = 32'h0000_0403;
      drive_commit(32'h1104, 7'h00, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("exl_no_trap",  {31'd0, exc_valid_o}, 32'd0);
      chk("exl_no_flush", {31'd0, flush_o},     32'd0);
      next_cycle();
      clear_inputs();
      status_i       = 0;
      cause_i        = 0;
      hw_int_async_i = 0;
      next_cycle();

      // ERET, then SYSCALL ignored while draining.
      epc_i = 32'h2000;
      push_eret(32'h2000);
      drive_commit(32'h1200, 7'h00, 1'b1, 1'b0, 32'h0);
      next_cycle();
      drive_commit(32'h1204, 7'h04, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("drain_sys1", {31'd0, exc_valid_o}, 32'd0);
      chk("drain_fl1",  {31'd0, flush_o},     32'd1);
      next_cycle();
      @(negedge clk);
      chk("drain_sys2", {31'd0, exc_valid_o}, 32'd0);
      next_cycle();
      clear_inputs();
      @(negedge clk);
      chk("eret_idle", {31'd0, flush_o}, 32'd0);
      next_cycle();

      // Stalled BREAK taken once on release.
      drive_commit(32'h1300, 7'h08, 1'b0, 1'b0, 32'h0);
      stall_i = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_no_exc", {31'd0, exc_valid_o}, 32'd0);
         next_cycle();
      end
      stall_i = 0;
      push_exc(5'h09, 32'h1300, 1'b0, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("bp_once", {31'd0, exc_valid_o}, 32'd0);
      next_cycle();
      clear_inputs();
      wait_idle();

      // Reset during DRAIN, then a normal trap.
      push_exc(5'h0c, 32'h1400, 1'b0, 32'h0);
      drive_commit(32'h1400, 7'h10, 1'b0, 1'b0, 32'h0);
      next_cycle();
      clear_inputs();
      rst_n = 0;
      #1;
      chk("rst_mid_flush", {31'd0, flush_o},          32'd0);
      chk("rst_mid_redir", {31'd0, redirect_valid_o}, 32'd0);
      next_cycle();
      rst_n = 1;
      next_cycle();
      push_exc(5'h0c, 32'h1500, 1'b0, 32'h0);
      drive_commit(32'h1500, 7'h10, 1'b0, 1'b0, 32'h0);
      next_cycle();
      clear_inputs();
      wait_idle();

      chk("sb_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
